// File: rtl/alu_issue_ctrl_if.sv
// Request / ALU / response bundle for alu_issue_ctrl.
// master: the issue controller itself (accepts requests, drives the ALU, returns responses).
// slave:  its surroundings (decode stage, the ALU and the response consumer).
interface alu_issue_ctrl_if #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned FUNCT_W = 6
);
   logic               req_valid;
   logic               req_ready;
   logic [FUNCT_W-1:0] req_funct;
   logic [WIDTH-1:0]   req_a;
   logic [WIDTH-1:0]   req_b;

   logic [WIDTH-1:0]   alu_A;
   logic [WIDTH-1:0]   alu_B;
   logic [2:0]         alu_op;
   logic [WIDTH-1:0]   alu_Res;
   logic               alu_Zflag;

   logic               rsp_valid;
   logic               rsp_ready;
   logic [WIDTH-1:0]   rsp_res;
   logic               rsp_zero;
   logic               rsp_err;

   modport master (
      input  req_valid, req_funct, req_a, req_b,
      output req_ready,
      output alu_A, alu_B, alu_op,
      input  alu_Res, alu_Zflag,
      output rsp_valid, rsp_res, rsp_zero, rsp_err,
      input  rsp_ready
   );

   modport slave (
      output req_valid, req_funct, req_a, req_b,
      input  req_ready,
      input  alu_A, alu_B, alu_op,
      output alu_Res, alu_Zflag,
      input  rsp_valid, rsp_res, rsp_zero, rsp_err,
      output rsp_ready
   );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue controller between decode and the ALU: takes an R-type request, drives the ALU
// for a fixed latency, captures result/zero flag and returns them on a response port.
// All outputs are registered.
module alu_issue_ctrl #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned FUNCT_W = 6,
   parameter int unsigned ALU_LAT = 1
) (
   input  logic             CLK,
   input  logic             RSTn,
   alu_issue_ctrl_if.master bus,
   output logic             busy
);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   localparam logic [2:0] OpAdd  = 3'b000;
   localparam logic [2:0] OpAnd  = 3'b001;
   localparam logic [2:0] OpOr   = 3'b010;
   localparam logic [2:0] OpSub  = 3'b011;
   localparam logic [2:0] OpMul  = 3'b100;
   localparam logic [2:0] OpSlt  = 3'b101;
   // Idle op: the ALU yields 0 while nothing is in flight.
   localparam logic [2:0] OpIdle = 3'b111;

   localparam logic [FUNCT_W-1:0] FnAdd  = FUNCT_W'(6'h20);
   localparam logic [FUNCT_W-1:0] FnAddu = FUNCT_W'(6'h21);
   localparam logic [FUNCT_W-1:0] FnSub  = FUNCT_W'(6'h22);
   localparam logic [FUNCT_W-1:0] FnSubu = FUNCT_W'(6'h23);
   localparam logic [FUNCT_W-1:0] FnAnd  = FUNCT_W'(6'h24);
   localparam logic [FUNCT_W-1:0] FnOr   = FUNCT_W'(6'h25);
   localparam logic [FUNCT_W-1:0] FnMul  = FUNCT_W'(6'h18);
   localparam logic [FUNCT_W-1:0] FnSlt  = FUNCT_W'(6'h2A);

   // Wait counter reload; ALU_LAT is limited to 1..15 so four bits suffice.
   localparam logic [3:0] LatCnt = 4'(ALU_LAT);

   state_e           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic [2:0]       alu_op_q, alu_op_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0] rsp_res_q, rsp_res_d;
   logic             rsp_zero_q, rsp_zero_d;
   logic             rsp_err_q, rsp_err_d;
   logic             req_ready_q, req_ready_d;
   logic             busy_q, busy_d;

   logic             funct_legal;
   logic [2:0]       mapped_op;

   // Map the R-type funct code onto the 3-bit ALU op; anything unlisted is illegal.
   always_comb begin
      funct_legal = 1'b1;
      mapped_op   = OpIdle;
      case (bus.req_funct)
         FnAdd, FnAddu: mapped_op = OpAdd;
         FnAnd:         mapped_op = OpAnd;
         FnOr:          mapped_op = OpOr;
         FnSub, FnSubu: mapped_op = OpSub;
         FnMul:         mapped_op = OpMul;
         FnSlt:         mapped_op = OpSlt;
         default:       funct_legal = 1'b0;
      endcase
   end

   // Next-state and next-output logic for the IDLE/WAIT/RESP sequence.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_op_d    = alu_op_q;
      rsp_valid_d = rsp_valid_q;
      rsp_res_d   = rsp_res_q;
      rsp_zero_d  = rsp_zero_q;
      rsp_err_d   = rsp_err_q;

      unique case (state_q)
         StIdle: begin
            if (bus.req_valid && req_ready_q) begin
               alu_a_d = bus.req_a;
               alu_b_d = bus.req_b;
               if (funct_legal) begin
                  alu_op_d = mapped_op;
                  cnt_d    = LatCnt;
                  state_d  = StWait;
               end else begin
                  // Illegal funct: answer straight away, the ALU op stays idle.
                  rsp_res_d   = '0;
                  rsp_zero_d  = 1'b0;
                  rsp_err_d   = 1'b1;
                  rsp_valid_d = 1'b1;
                  state_d     = StResp;
               end
            end
         end
         StWait: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               rsp_res_d   = bus.alu_Res;
               rsp_zero_d  = bus.alu_Zflag;
               rsp_err_d   = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = StResp;
            end
         end
         StResp: begin
            // Response fields keep their values after the handshake; only valid drops.
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               alu_op_d    = OpIdle;
               state_d     = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      req_ready_d = (state_d == StIdle);
      busy_d      = ~req_ready_d;
   end

   // State and registered outputs; req_ready stays low while reset is asserted.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q     <= StIdle;
         cnt_q       <= 4'd0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_op_q    <= OpIdle;
         rsp_valid_q <= 1'b0;
         rsp_res_q   <= '0;
         rsp_zero_q  <= 1'b0;
         rsp_err_q   <= 1'b0;
         req_ready_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_op_q    <= alu_op_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_res_q   <= rsp_res_d;
         rsp_zero_q  <= rsp_zero_d;
         rsp_err_q   <= rsp_err_d;
         req_ready_q <= req_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.alu_A     = alu_a_q;
   assign bus.alu_B     = alu_b_q;
   assign bus.alu_op    = alu_op_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_res   = rsp_res_q;
   assign bus.rsp_zero  = rsp_zero_q;
   assign bus.rsp_err   = rsp_err_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: unit 0 with ALU_LAT=1, unit 1 with ALU_LAT=3, each talking
// to a combinational ALU. A transaction-level model predicts every output each cycle;
// directed vectors add literal expectations.
module tb_alu_issue_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Stimulus, indexed by unit.
   logic [1:0]  req_valid;
   logic [5:0]  req_funct [2];
   logic [31:0] req_a [2];
   logic [31:0] req_b [2];
   logic [1:0]  rsp_ready;

   // Observed DUT outputs.
   logic [1:0]  o_ready, o_busy, o_valid, o_zero, o_err;
   logic [31:0] o_res [2];
   logic [31:0] o_a [2];
   logic [31:0] o_b [2];
   logic [2:0]  o_op [2];

   // Model outputs.
   logic [1:0]  e_ready, e_busy, e_valid, e_zero, e_err, pend;
   logic [31:0] e_res [2];
   logic [31:0] e_a [2];
   logic [31:0] e_b [2];
   logic [2:0]  e_op [2];
   logic [31:0] want [2];
   int          due [2];
   int          cyc;

   int n_checks = 0;
   int n_fail = 0;

   // Combinational ALU seen by the DUTs.
   function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a & b;
         3'd2:    return a | b;
         3'd3:    return a - b;
         3'd4:    return a * b;
         3'd5:    return (a < b) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   alu_issue_ctrl_if #(.WIDTH(32), .FUNCT_W(6)) u0_if ();
   alu_issue_ctrl_if #(.WIDTH(32), .FUNCT_W(6)) u1_if ();

   alu_issue_ctrl #(.WIDTH(32), .FUNCT_W(6), .ALU_LAT(1)) u_dut0 (
      .CLK  (clk),
      .RSTn (rst_n),
      .bus  (u0_if),
      .busy (o_busy[0])
   );

   alu_issue_ctrl #(.WIDTH(32), .FUNCT_W(6), .ALU_LAT(3)) u_dut1 (
      .CLK  (clk),
      .RSTn (rst_n),
      .bus  (u1_if),
      .busy (o_busy[1])
   );

   logic [31:0] alu0_res, alu1_res;
   assign alu0_res          = alu_fn(u0_if.alu_op, u0_if.alu_A, u0_if.alu_B);
   assign alu1_res          = alu_fn(u1_if.alu_op, u1_if.alu_A, u1_if.alu_B);
   assign u0_if.alu_Res     = alu0_res;
   assign u0_if.alu_Zflag   = (alu0_res == 32'd0);
   assign u1_if.alu_Res     = alu1_res;
   assign u1_if.alu_Zflag   = (alu1_res == 32'd0);

   assign u0_if.req_valid = req_valid[0];
   assign u0_if.req_funct = req_funct[0];
   assign u0_if.req_a     = req_a[0];
   assign u0_if.req_b     = req_b[0];
   assign u0_if.rsp_ready = rsp_ready[0];
   assign u1_if.req_valid = req_valid[1];
   assign u1_if.req_funct = req_funct[1];
   assign u1_if.req_a     = req_a[1];
   assign u1_if.req_b     = req_b[1];
   assign u1_if.rsp_ready = rsp_ready[1];

   assign o_ready[0] = u0_if.req_ready;
   assign o_valid[0] = u0_if.rsp_valid;
   assign o_zero[0]  = u0_if.rsp_zero;
   assign o_err[0]   = u0_if.rsp_err;
   assign o_res[0]   = u0_if.rsp_res;
   assign o_a[0]     = u0_if.alu_A;
   assign o_b[0]     = u0_if.alu_B;
   assign o_op[0]    = u0_if.alu_op;
   assign o_ready[1] = u1_if.req_ready;
   assign o_valid[1] = u1_if.rsp_valid;
   assign o_zero[1]  = u1_if.rsp_zero;
   assign o_err[1]   = u1_if.rsp_err;
   assign o_res[1]   = u1_if.rsp_res;
   assign o_a[1]     = u1_if.alu_A;
   assign o_b[1]     = u1_if.alu_B;
   assign o_op[1]    = u1_if.alu_op;

   // Reference semantics straight from the funct code.
   function automatic logic fn_legal(input logic [5:0] f);
      return f inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h18, 6'h2A};
   endfunction

   function automatic logic [2:0] fn_op(input logic [5:0] f);
      case (f)
         6'h20, 6'h21: return 3'b000;
         6'h24:        return 3'b001;
         6'h25:        return 3'b010;
         6'h22, 6'h23: return 3'b011;
         6'h18:        return 3'b100;
         6'h2A:        return 3'b101;
         default:      return 3'b111;
      endcase
   endfunction

   function automatic logic [31:0] fn_res(input logic [5:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
      case (f)
         6'h20, 6'h21: return a + b;
         6'h24:        return a & b;
         6'h25:        return a | b;
         6'h22, 6'h23: return a - b;
         6'h18:        return a * b;
         6'h2A:        return (a < b) ? 32'd1 : 32'd0;
         default:      return 32'd0;
      endcase
   endfunction

   function automatic int lat_of(input int u);
      return (u == 0) ? 1 : 3;
   endfunction

   // Transaction model: an accepted request is answered at a known cycle stamp.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc <= 0;
         for (int u = 0; u < 2; u++) begin
            e_ready[u] <= 1'b0;
            e_busy[u]  <= 1'b0;
            e_valid[u] <= 1'b0;
            e_zero[u]  <= 1'b0;
            e_err[u]   <= 1'b0;
            pend[u]    <= 1'b0;
            e_res[u]   <= 32'd0;
            e_a[u]     <= 32'd0;
            e_b[u]     <= 32'd0;
            e_op[u]    <= 3'b111;
            want[u]    <= 32'd0;
            due[u]     <= 0;
         end
      end else begin
         cyc <= cyc + 1;
         for (int u = 0; u < 2; u++) begin
            if (e_ready[u] && req_valid[u]) begin
               e_a[u]     <= req_a[u];
               e_b[u]     <= req_b[u];
               e_ready[u] <= 1'b0;
               e_busy[u]  <= 1'b1;
               if (fn_legal(req_funct[u])) begin
                  e_op[u] <= fn_op(req_funct[u]);
                  want[u] <= fn_res(req_funct[u], req_a[u], req_b[u]);
                  pend[u] <= 1'b1;
                  due[u]  <= cyc + lat_of(u) + 1;
               end else begin
                  e_valid[u] <= 1'b1;
                  e_err[u]   <= 1'b1;
                  e_res[u]   <= 32'd0;
                  e_zero[u]  <= 1'b0;
               end
            end else if (pend[u] && cyc == due[u]) begin
               pend[u]    <= 1'b0;
               e_valid[u] <= 1'b1;
               e_res[u]   <= want[u];
               e_zero[u]  <= (want[u] == 32'd0);
               e_err[u]   <= 1'b0;
            end else if (e_valid[u] && rsp_ready[u]) begin
               e_valid[u] <= 1'b0;
               e_op[u]    <= 3'b111;
               e_ready[u] <= 1'b1;
               e_busy[u]  <= 1'b0;
            end else if (!pend[u] && !e_valid[u]) begin
               e_ready[u] <= 1'b1;
               e_busy[u]  <= 1'b0;
            end
         end
      end
   end

   task automatic chk(input string what, input int u, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s unit%0d @%0t: got 0x%08h expected 0x%08h", what, u, $time, act, exp);
      end
   endtask

   task automatic compare_all();
      for (int u = 0; u < 2; u++) begin
         chk("req_ready", u, 32'(o_ready[u]), 32'(e_ready[u]));
         chk("busy",      u, 32'(o_busy[u]),  32'(e_busy[u]));
         chk("rsp_valid", u, 32'(o_valid[u]), 32'(e_valid[u]));
         chk("rsp_err",   u, 32'(o_err[u]),   32'(e_err[u]));
         chk("rsp_zero",  u, 32'(o_zero[u]),  32'(e_zero[u]));
         chk("rsp_res",   u, o_res[u],        e_res[u]);
         chk("alu_A",     u, o_a[u],          e_a[u]);
         chk("alu_B",     u, o_b[u],          e_b[u]);
         chk("alu_op",    u, 32'(o_op[u]),    32'(e_op[u]));
      end
   endtask

   // One clock: compare on the falling edge, return 1ns after the rising edge.
   task automatic step();
      @(negedge clk);
      compare_all();
      @(posedge clk);
      #1;
   endtask

   // Present a request and hold it until the rising edge that accepts it.
   task automatic issue(input int u, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b);
      logic got;
      got = 1'b0;
      req_valid[u] = 1'b1;
      req_funct[u] = f;
      req_a[u]     = a;
      req_b[u]     = b;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         compare_all();
         got = o_ready[u];
         @(posedge clk);
         #1;
      end
      req_valid[u] = 1'b0;
      chk("accepted", u, 32'(got), 32'd1);
   endtask

   // Rising edges after the accept edge until rsp_valid is seen (0 = set on the accept edge).
   task automatic wait_rsp(input int u, output int lat);
      lat = 0;
      while (!o_valid[u] && lat < 60) begin
         step();
         lat++;
      end
   endtask

   task automatic consume(input int u);
      rsp_ready[u] = 1'b1;
      step();
      rsp_ready[u] = 1'b0;
   endtask

   // Full transaction with literal expectations on the response.
   task automatic run_op(input int u, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input int x_lat, input logic [2:0] x_op,
                         input logic [31:0] x_res, input logic x_zero, input logic x_err);
      int lat;
      issue(u, f, a, b);
      chk("lit_alu_op", u, 32'(o_op[u]), 32'(x_op));
      wait_rsp(u, lat);
      chk("lit_latency", u, 32'(lat), 32'(x_lat));
      chk("lit_rsp_res", u, o_res[u], x_res);
      chk("lit_rsp_zero", u, 32'(o_zero[u]), 32'(x_zero));
      chk("lit_rsp_err", u, 32'(o_err[u]), 32'(x_err));
      chk("lit_model_res", u, e_res[u], x_res);
      consume(u);
      chk("lit_valid_dropped", u, 32'(o_valid[u]), 32'd0);
      chk("lit_op_idle", u, 32'(o_op[u]), 32'd7);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      req_valid = '0;
      rsp_ready = '0;
      for (int u = 0; u < 2; u++) begin
         req_funct[u] = '0;
         req_a[u]     = '0;
         req_b[u]     = '0;
      end

      // Reset values, then ready on the first edge after release.
      repeat (3) step();
      chk("rst_req_ready", 0, 32'(o_ready[0]), 32'd0);
      chk("rst_alu_op", 0, 32'(o_op[0]), 32'd7);
      chk("rst_busy", 1, 32'(o_busy[1]), 32'd0);
      rst_n = 1'b1;
      step();
      chk("post_rst_ready", 0, 32'(o_ready[0]), 32'd1);
      chk("post_rst_ready", 1, 32'(o_ready[1]), 32'd1);

      // Legal ops on the ALU_LAT=1 unit.
      run_op(0, 6'h20, 32'd5, 32'd7, 2, 3'b000, 32'd12, 1'b0, 1'b0);
      run_op(0, 6'h22, 32'h1234, 32'h1234, 2, 3'b011, 32'd0, 1'b1, 1'b0);
      run_op(0, 6'h2A, 32'd3, 32'hFFFF_FFFF, 2, 3'b101, 32'd1, 1'b0, 1'b0);
      run_op(0, 6'h2A, 32'd9, 32'd9, 2, 3'b101, 32'd0, 1'b1, 1'b0);
      run_op(0, 6'h18, 32'h0001_0000, 32'h0001_0001, 2, 3'b100, 32'h0001_0000, 1'b0, 1'b0);
      run_op(0, 6'h23, 32'd5, 32'd7, 2, 3'b011, 32'hFFFF_FFFE, 1'b0, 1'b0);
      run_op(0, 6'h21, 32'hFFFF_FFFF, 32'd2, 2, 3'b000, 32'd1, 1'b0, 1'b0);

      // Illegal funct codes: immediate error response, op stays idle.
      run_op(0, 6'h00, 32'd11, 32'd22, 0, 3'b111, 32'd0, 1'b0, 1'b1);
      run_op(1, 6'h3F, 32'd1, 32'd0, 0, 3'b111, 32'd0, 1'b0, 1'b1);

      // Response back-pressure with a new request waiting.
      begin
         int lat;
         issue(0, 6'h24, 32'h0000_F0F0, 32'h0000_FF00);
         wait_rsp(0, lat);
         req_valid[0] = 1'b1;
         req_funct[0] = 6'h25;
         req_a[0]     = 32'd1;
         req_b[0]     = 32'd2;
         for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_req_ready", 0, 32'(o_ready[0]), 32'd0);
            chk("bp_rsp_valid", 0, 32'(o_valid[0]), 32'd1);
            chk("bp_rsp_res", 0, o_res[0], 32'h0000_F000);
         end
         consume(0);
         chk("bp_ready_after", 0, 32'(o_ready[0]), 32'd1);
         chk("bp_res_kept", 0, o_res[0], 32'h0000_F000);
         run_op(0, 6'h25, 32'd1, 32'd2, 2, 3'b010, 32'd3, 1'b0, 1'b0);
      end

      // ALU_LAT=3 unit: reset mid-WAIT drops the operation.
      issue(1, 6'h20, 32'd5, 32'd7);
      step();
      rst_n = 1'b0;
      repeat (2) step();
      chk("midrst_valid", 1, 32'(o_valid[1]), 32'd0);
      chk("midrst_op", 1, 32'(o_op[1]), 32'd7);
      chk("midrst_ready", 1, 32'(o_ready[1]), 32'd0);
      rst_n = 1'b1;
      step();
      chk("midrst_ready_after", 1, 32'(o_ready[1]), 32'd1);
      repeat (4) step();
      chk("midrst_no_rsp", 1, 32'(o_valid[1]), 32'd0);

      run_op(1, 6'h20, 32'd5, 32'd7, 4, 3'b000, 32'd12, 1'b0, 1'b0);
      run_op(1, 6'h18, 32'd6, 32'd7, 4, 3'b100, 32'd42, 1'b0, 1'b0);
      run_op(1, 6'h22, 32'd8, 32'd8, 4, 3'b011, 32'd0, 1'b1, 1'b0);

      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
